inner_product_seq: RTL and testbench

Sequencing controller that computes the unsigned inner product of long vectors (up to MAXC chunks of N elements) by streaming one N-element chunk per cycle through a shared combinational chunk-dot-product datapath. It accumulates the partial sums and returns one result per job. It sits between a vector source (valid/ready) and a result consumer (valid/ready), is started by a single-cycle job command, and is the standard way the codebase drives the inner-product datapath over vectors longer than N.

---
 rtl/inner_product_seq_pkg.sv | 20 ++
 rtl/ip_chunk_dot.sv | 29 ++
 rtl/inner_product_seq.sv | 114 +++++++++++
 tb/tb_inner_product_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/inner_product_seq_pkg.sv
// Shared types and width helpers for the inner-product sequencer.
package inner_product_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of one exact chunk partial sum.
    function automatic int pw_f(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

    // Width of the accumulator, exact for up to maxc chunks.
    function automatic int accw_f(input int n, input int dw, input int maxc);
        return 2 * dw + $clog2(n * maxc);
    endfunction

endpackage

// File: rtl/ip_chunk_dot.sv
// Combinational dot product of one N-element chunk.
module ip_chunk_dot
    import inner_product_seq_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic [DW*N-1:0]        a,
    input  logic [DW*N-1:0]        b,
    output logic [pw_f(N, DW)-1:0] sum
);

    localparam int PW = pw_f(N, DW);

    logic [2*DW-1:0] prod [N];

    for (genvar i = 0; i < N; i++) begin : g_mul
        assign prod[i] = (2*DW)'(a[i*DW +: DW]) * (2*DW)'(b[i*DW +: DW]);
    end

    // Adder reduction of the element products.
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum = sum + PW'(prod[i]);
        end
    end

endmodule

// File: rtl/inner_product_seq.sv
// Job sequencer streaming chunks through ip_chunk_dot and accumulating.
module inner_product_seq
    import inner_product_seq_pkg::*;
#(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int MAXC = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [$clog2(MAXC):0]             cfg_len,
    input  logic                              abort,
    output logic                              busy,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DW*N-1:0]                   in_a,
    input  logic [DW*N-1:0]                   in_b,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [accw_f(N, DW, MAXC)-1:0]    out_data
);

    localparam int LW   = $clog2(MAXC) + 1;
    localparam int PW   = pw_f(N, DW);
    localparam int ACCW = accw_f(N, DW, MAXC);
    localparam logic [LW-1:0] MAXC_L = LW'(MAXC);

    state_t          state, state_d;
    logic [ACCW-1:0] acc, acc_d;
    logic [LW-1:0]   cnt, cnt_d;
    logic [LW-1:0]   len, len_d;
    logic [PW-1:0]   chunk_sum;

    ip_chunk_dot #(.N(N), .DW(DW)) u_dot (
        .a   (in_a),
        .b   (in_b),
        .sum (chunk_sum)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Accumulator, beat counter and clamped job length registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            len <= '0;
        end else begin
            acc <= acc_d;
            cnt <= cnt_d;
            len <= len_d;
        end
    end

    // Next-state and datapath update; abort overrides every other event.
    always_comb begin
        state_d = state;
        acc_d   = acc;
        cnt_d   = cnt;
        len_d   = len;
        if (abort) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_d = '0;
                        cnt_d = '0;
                        if (cfg_len == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                            len_d   = (cfg_len > MAXC_L) ? MAXC_L : cfg_len;
                        end
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        acc_d = acc + ACCW'(chunk_sum);
                        cnt_d = cnt + LW'(1);
                        if (cnt == len - LW'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake outputs decode from state only.
    always_comb begin
        busy      = (state != IDLE);
        in_ready  = (state == RUN);
        out_valid = (state == DONE);
        out_data  = acc;
    end

endmodule

// File: tb/tb_inner_product_seq.sv
// Scoreboard bench for inner_product_seq with directed, hand-computed vectors.
module tb_inner_product_seq;
    import inner_product_seq_pkg::*;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int MAXC = 16;
    localparam int LW   = $clog2(MAXC) + 1;
    localparam int ACCW = accw_f(N, DW, MAXC);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [LW-1:0]   cfg_len;
    logic            abort;
    logic            busy;
    logic            in_valid;
    logic            in_ready;
    logic [DW*N-1:0] in_a;
    logic [DW*N-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out_data;

    int checks = 0;
    int errors = 0;
    logic [ACCW-1:0] sb [$];

    inner_product_seq #(.N(N), .DW(DW), .MAXC(MAXC)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_len   (cfg_len),
        .abort     (abort),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack(input logic [7:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a job command; the expected result is queued unless the job is doomed.
    task automatic start_job(input int len, input logic [ACCW-1:0] exp, input bit push);
        if (push) sb.push_back(exp);
        start   = 1'b1;
        cfg_len = LW'(len);
        tick();
        start   = 1'b0;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: every result handshake is compared against the scoreboard head.
    initial begin
        logic [ACCW-1:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got %0d, expected no result at %0t", out_data, $time);
                end else begin
                    exp = sb.pop_front();
                    if (out_data !== exp) begin
                        errors++;
                        $display("FAIL result: got %0d, expected %0d at %0t", out_data, exp, $time);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; cfg_len = '0; abort = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        #12;
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        rst = 1'b0;
        tick();

        // Single chunk: result exactly one cycle after the beat.
        start_job(1, 30, 1);
        check("single_in_ready", in_ready, 1);
        beat(pack(1, 2, 3, 4), pack(1, 2, 3, 4));
        check("single_out_valid", out_valid, 1);
        tick();
        check("single_idle", busy, 0);
        tick();

        // Full scale: 16 beats of 255s, result right after the 16th.
        start_job(16, 4161600, 1);
        for (int i = 0; i < 15; i++) beat(pack(255, 255, 255, 255), pack(255, 255, 255, 255));
        check("full_not_early", out_valid, 0);
        beat(pack(255, 255, 255, 255), pack(255, 255, 255, 255));
        check("full_out_valid", out_valid, 1);
        check("full_out_data", out_data, 4161600);
        tick();
        tick();

        // Stalls and backpressure.
        out_ready = 1'b0;
        start_job(3, 24, 1);
        beat(pack(1, 1, 1, 1), pack(2, 2, 2, 2));
        tick();
        tick();
        beat(pack(1, 1, 1, 1), pack(2, 2, 2, 2));
        tick();
        check("stall_not_early", out_valid, 0);
        beat(pack(1, 1, 1, 1), pack(2, 2, 2, 2));
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", out_valid, 1);
            check("hold_out_data", out_data, 24);
            check("hold_busy", busy, 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("release_idle", busy, 0);
        tick();

        // Zero-length job.
        start_job(0, 0, 1);
        check("zero_out_valid", out_valid, 1);
        check("zero_out_data", out_data, 0);
        tick();
        check("zero_idle", busy, 0);
        tick();

        // Length 20 clamps to 16; a start pulse inside RUN is ignored.
        start_job(20, 160, 1);
        for (int i = 0; i < 15; i++) begin
            if (i == 4) begin
                start = 1'b1;
                cfg_len = LW'(1);
            end
            beat(pack(1, 1, 1, 1), pack(1, 2, 3, 4));
            start = 1'b0;
        end
        check("clamp_not_early", out_valid, 0);
        check("clamp_in_ready", in_ready, 1);
        beat(pack(1, 1, 1, 1), pack(1, 2, 3, 4));
        check("clamp_out_valid", out_valid, 1);
        tick();
        tick();

        // Abort together with the third accepted beat.
        start_job(3, 0, 0);
        beat(pack(1, 1, 1, 1), pack(2, 2, 2, 2));
        beat(pack(1, 1, 1, 1), pack(2, 2, 2, 2));
        abort = 1'b1;
        beat(pack(1, 1, 1, 1), pack(2, 2, 2, 2));
        abort = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        tick();
        tick();
        start_job(1, 8, 1);
        beat(pack(1, 1, 1, 1), pack(2, 2, 2, 2));
        check("post_abort_valid", out_valid, 1);
        tick();
        tick();

        // Asynchronous reset mid-RUN after two beats.
        start_job(3, 0, 0);
        beat(pack(1, 2, 3, 4), pack(1, 2, 3, 4));
        beat(pack(1, 2, 3, 4), pack(1, 2, 3, 4));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_in_ready", in_ready, 0);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, 0);
        tick();
        rst = 1'b0;
        tick();
        start_job(1, 30, 1);
        beat(pack(4, 3, 2, 1), pack(4, 3, 2, 1));
        check("post_rst_valid", out_valid, 1);
        tick();
        tick();
        tick();

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
